oddeven_seq_gen: RTL and testbench
==================================

# oddeven_seq_gen

Sequence generator that produces a stream of 4-bit values that are all even or all odd, stepping by 2 in a selected direction with wrap-around. It delivers each value through a valid/ready handshake. It is the source side of the lab's odd/even datapath: its output feeds a downstream odd/even detector, which must report the parity selected here for every value. A single start pulse launches a burst of a programmable length, and a done pulse marks its completion.

## Interface
- WIDTH, 4, data width; values step modulo 2^WIDTH; WIDTH >= 2
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  burst request; sampled only in IDLE
- parity_sel  input  1  0 = even stream, 1 = odd stream; latched on accepted start
- dir  input  1  0 = count up, 1 = count down; latched on accepted start
- count_len  input  WIDTH  number of values in burst; 0 means 2^(WIDTH-1) (full set); latched on accepted start
- out_ready  input  1  downstream can accept out_data this cycle
- out_valid  output  1  out_data is valid
- out_data  output  WIDTH  current stream value
- out_last  output  1  out_data is the final value of the burst; meaningful only with out_valid
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse after the final handshake

## Operation
- One clock; reset is asynchronous and active-low (clk, rst_n).
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch parity_sel, dir, and count_len; load the remaining-count register (count_len, or 2^(WIDTH-1) if 0); load the first value; go to RUN.
- First value:
  - up/even = 0
  - up/odd = 1
  - down/even = 2^WIDTH-2 (14)
  - down/odd = 2^WIDTH-1 (15)
- RUN: out_valid=1. A handshake (out_valid & out_ready) advances out_data by +2 (up) or -2 (down), modulo 2^WIDTH, and decrements the remaining count.
- Wrap-around:
  - up: 14 -> 0 and 15 -> 1
  - down: 0 -> 14 and 1 -> 15
- out_last=1 while remaining count = 1.
- A handshake with out_last=1 goes to DONE.
- DONE: lasts one cycle with done=1, out_valid=0, then returns to IDLE.
- start is ignored in RUN and DONE. Changes to parity_sel, dir, or count_len after the start is accepted do not affect the running burst.
- Invariant: out_data[0] == latched parity_sel whenever out_valid=1.
- A count_len above 2^(WIDTH-1) repeats values after wrap. This is legal: the stream keeps stepping with no error flag.
- Async reset asserted at any time, including mid-burst: state goes to IDLE immediately; all outputs go to 0; the burst is discarded and no done pulse is produced.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, done=0; state IDLE.
- start accepted at edge T -> out_valid=1, busy=1, and the first value on out_data after T.
- out_data and out_last are registered and remain stable while out_valid=1 and out_ready=0.
- Throughput: one value per cycle while out_ready is held high.
- Burst of N values with out_ready always high:
  - values occupy cycles T+1 .. T+N
  - done=1 in cycle T+N+1
  - IDLE in T+N+2
  - the next start is sampled at the edge ending cycle T+N+2
- No combinational path from out_ready to out_valid or out_data.

## Test plan
- Reset: rst_n=0 -> all outputs 0. Release, then start with parity_sel=0, dir=0, count_len=3 and ready high -> values 0,2,4; out_last on 4; done 1 cycle later.
- Odd up with wrap: parity_sel=1, dir=0, count_len=0 -> 8 values 1,3,5,7,9,11,13,15; out_last on 15. Then count_len=10 -> 1..15,1,3.
- Down with wrap: parity_sel=0, dir=1, count_len=9 -> 14,12,10,8,6,4,2,0,14; every LSB = 0.
- Backpressure: burst 1,3,5 with out_ready toggled 1,0,0,1,0,1 -> each value held stable until its handshake; no value skipped or duplicated.
- Start/config ignored while busy: pulse start and flip parity_sel mid-burst -> burst unchanged; no second burst starts.
- Reset mid-burst: assert rst_n=0 after 2 handshakes -> outputs 0 in the same cycle; no done pulse. Restart -> first value again.

Source files
------------

// File: rtl/oddeven_seq_gen.sv
// oddeven_seq_gen
//
// Emits a burst of WIDTH-bit values that all share one parity (even or odd),
// stepping by 2 up or down with wrap-around modulo 2^WIDTH. Each value is
// offered on a valid/ready handshake. A start pulse in IDLE launches a burst;
// a one-cycle done pulse follows the final handshake.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       burst request, honoured only in IDLE
//   parity_sel  0 = even stream, 1 = odd stream (captured on accepted start)
//   dir         0 = count up, 1 = count down (captured on accepted start)
//   count_len   burst length, 0 selects 2^(WIDTH-1) (captured on accepted start)
//   out_ready   downstream accepts out_data this cycle
//   out_valid   out_data holds a stream value
//   out_data    current stream value (registered)
//   out_last    out_data is the final value of the burst (registered)
//   busy        high while a burst is running or completing
//   done        one-cycle pulse after the final handshake

module oddeven_seq_gen #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             parity_sel,
   input  logic             dir,
   input  logic [WIDTH-1:0] count_len,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   // Size of the full same-parity set; a count_len of 0 selects it.
   localparam logic [WIDTH-1:0] HalfSet = WIDTH'(1) << (WIDTH - 1);
   localparam logic [WIDTH-1:0] Step    = WIDTH'(2);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e           state_q;
   logic             dir_q;
   logic [WIDTH-1:0] rem_q;

   logic [WIDTH-1:0] load_len;
   logic [WIDTH-1:0] first_val;
   logic [WIDTH-1:0] next_val;

   always_comb begin
      load_len  = (count_len == '0) ? HalfSet : count_len;
      // Up starts at the bottom of the set, down at the top; the LSB carries
      // the parity and stepping by 2 never disturbs it, so parity needs no
      // register of its own.
      first_val = dir ? {{(WIDTH - 1){1'b1}}, parity_sel}
                      : {{(WIDTH - 1){1'b0}}, parity_sel};
      next_val  = dir_q ? (out_data - Step) : (out_data + Step);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         dir_q     <= 1'b0;
         rem_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  dir_q     <= dir;
                  rem_q     <= load_len;
                  out_data  <= first_val;
                  out_last  <= (load_len == WIDTH'(1));
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state_q   <= StRun;
               end
            end

            StRun: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     rem_q     <= '0;
                     state_q   <= StDone;
                  end else begin
                     out_data <= next_val;
                     rem_q    <= rem_q - WIDTH'(1);
                     // Next value is last when two remain before this step.
                     out_last <= (rem_q == WIDTH'(2));
                  end
               end
            end

            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oddeven_seq_gen.sv
module tb_oddeven_seq_gen;

   localparam int unsigned WIDTH = 4;

   logic             clk        = 1'b0;
   logic             rst_n      = 1'b0;
   logic             start      = 1'b0;
   logic             parity_sel = 1'b0;
   logic             dir        = 1'b0;
   logic [WIDTH-1:0] count_len  = '0;
   logic             out_ready  = 1'b0;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;
   logic             done;

   int errors = 0;
   int checks = 0;

   logic [3:0] exp_up10 [10] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd1, 4'd3};
   logic [3:0] exp_dn9  [9]  = '{4'd14, 4'd12, 4'd10, 4'd8, 4'd6, 4'd4, 4'd2, 4'd0, 4'd14};

   oddeven_seq_gen #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .parity_sel (parity_sel),
      .dir        (dir),
      .count_len  (count_len),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the value currently offered without advancing.
   task automatic look(input string tag, input logic [3:0] d, input logic l, input logic p);
      chk({tag, " valid"}, 32'(out_valid), 32'd1);
      chk({tag, " data"},  32'(out_data),  32'(d));
      chk({tag, " last"},  32'(out_last),  32'(l));
      chk({tag, " busy"},  32'(busy),      32'd1);
      chk({tag, " lsb"},   32'(out_data[0]), 32'(p));
   endtask

   task automatic beat(input string tag, input logic [3:0] d, input logic l, input logic p);
      look(tag, d, l, p);
      tick();
   endtask

   task automatic start_burst(input logic p, input logic d, input logic [3:0] len);
      start      = 1'b1;
      parity_sel = p;
      dir        = d;
      count_len  = len;
      tick();
      start      = 1'b0;
   endtask

   task automatic finish_burst(input string tag);
      chk({tag, " done valid"}, 32'(out_valid), 32'd0);
      chk({tag, " done pulse"}, 32'(done),      32'd1);
      chk({tag, " done busy"},  32'(busy),      32'd1);
      tick();
      chk({tag, " idle done"},  32'(done),      32'd0);
      chk({tag, " idle busy"},  32'(busy),      32'd0);
      chk({tag, " idle valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      // Reset
      tick();
      tick();
      chk("rst valid", 32'(out_valid), 32'd0);
      chk("rst data",  32'(out_data),  32'd0);
      chk("rst last",  32'(out_last),  32'd0);
      chk("rst busy",  32'(busy),      32'd0);
      chk("rst done",  32'(done),      32'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();

      // Even up, length 3
      start_burst(1'b0, 1'b0, 4'd3);
      beat("t1", 4'd0, 1'b0, 1'b0);
      beat("t1", 4'd2, 1'b0, 1'b0);
      beat("t1", 4'd4, 1'b1, 1'b0);
      finish_burst("t1");

      // Odd up, length 0 -> full set of 8
      start_burst(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 8; i++) beat("t2a", 4'(2 * i + 1), (i == 7), 1'b1);
      finish_burst("t2a");

      // Odd up, length 10 -> wraps and repeats
      start_burst(1'b1, 1'b0, 4'd10);
      for (int i = 0; i < 10; i++) beat("t2b", exp_up10[i], (i == 9), 1'b1);
      finish_burst("t2b");

      // Even down, length 9 -> wraps 0 -> 14
      start_burst(1'b0, 1'b1, 4'd9);
      for (int i = 0; i < 9; i++) beat("t3", exp_dn9[i], (i == 8), 1'b0);
      finish_burst("t3");

      // Backpressure: ready 1,0,0,1,0,1
      start_burst(1'b1, 1'b0, 4'd3);
      out_ready = 1'b1; look("t4 c1", 4'd1, 1'b0, 1'b1); tick();
      out_ready = 1'b0; look("t4 c2", 4'd3, 1'b0, 1'b1); tick();
      out_ready = 1'b0; look("t4 c3", 4'd3, 1'b0, 1'b1); tick();
      out_ready = 1'b1; look("t4 c4", 4'd3, 1'b0, 1'b1); tick();
      out_ready = 1'b0; look("t4 c5", 4'd5, 1'b1, 1'b1); tick();
      out_ready = 1'b1; look("t4 c6", 4'd5, 1'b1, 1'b1); tick();
      finish_burst("t4");

      // start and config changes ignored mid-burst
      start_burst(1'b0, 1'b0, 4'd4);
      beat("t5", 4'd0, 1'b0, 1'b0);
      start      = 1'b1;
      parity_sel = 1'b1;
      dir        = 1'b1;
      count_len  = 4'd7;
      beat("t5", 4'd2, 1'b0, 1'b0);
      start      = 1'b0;
      beat("t5", 4'd4, 1'b0, 1'b0);
      beat("t5", 4'd6, 1'b1, 1'b0);
      finish_burst("t5");
      tick();
      chk("t5 no rerun valid", 32'(out_valid), 32'd0);
      chk("t5 no rerun busy",  32'(busy),      32'd0);

      // Reset mid-burst after two handshakes
      start_burst(1'b1, 1'b0, 4'd5);
      beat("t6", 4'd1, 1'b0, 1'b1);
      beat("t6", 4'd3, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6 rst valid", 32'(out_valid), 32'd0);
      chk("t6 rst data",  32'(out_data),  32'd0);
      chk("t6 rst last",  32'(out_last),  32'd0);
      chk("t6 rst busy",  32'(busy),      32'd0);
      chk("t6 rst done",  32'(done),      32'd0);
      tick();
      chk("t6 rst no done", 32'(done), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6 post rst done",  32'(done),      32'd0);
      chk("t6 post rst valid", 32'(out_valid), 32'd0);
      start_burst(1'b1, 1'b0, 4'd2);
      beat("t6r", 4'd1, 1'b0, 1'b1);
      beat("t6r", 4'd3, 1'b1, 1'b1);
      finish_burst("t6r");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
